mem_read_streamer: RTL and testbench

Consumes a start/end address range and streams the contents of a synchronous-read memory (pixel/weight RAM) as a valid/ready beat stream with a last flag.
- Sits between the address-counter stage and the MAC/compute pipeline.
- Generates addresses start..end internally, one per cycle when credit allows.
- Absorbs the memory read latency and downstream backpressure with an internal credit-managed FIFO.

---
 rtl/mem_read_streamer.sv | 186 ++++++++++++++++++
 tb/tb_mem_read_streamer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_streamer.sv
`timescale 1ns/1ps
// mem_read_streamer: streams mem[start..end] from a synchronous-read RAM as a valid/ready beat stream.
// Define MEM_READ_STREAMER_STALL_CNT_EN to add stall_cnt_o, a saturating count of valid_o & !ready_i cycles.
module mem_read_streamer #(
    parameter int AddrBits    = 10,
    parameter int DataBits    = 8,
    parameter int ReadLatency = 1,
    parameter int FifoDepth   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [AddrBits-1:0] start_addr_i,
    input  logic [AddrBits-1:0] end_addr_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                mem_rd_en_o,
    output logic [AddrBits-1:0] mem_addr_o,
    input  logic [DataBits-1:0] mem_data_i,
    output logic [DataBits-1:0] data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                last_o
`ifdef MEM_READ_STREAMER_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt_o
`endif
);

    localparam int CntBits = $clog2(FifoDepth + 1);
    localparam int PtrBits = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

    if (ReadLatency < 1 || FifoDepth < ReadLatency + 2) begin : gen_param_check
        $error("mem_read_streamer: need ReadLatency >= 1 and FifoDepth >= ReadLatency+2");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e              state_q, state_d;
    logic [AddrBits-1:0] curAddr_q, curAddr_d;
    logic [AddrBits-1:0] endAddr_q, endAddr_d;
    logic                done_q, done_d;
    logic                rdEn_q, rdLast_q;
    logic [AddrBits-1:0] rdAddr_q;
    logic [CntBits-1:0]  inFlight_q, count_q;
    logic [PtrBits-1:0]  wrPtr_q, rdPtr_q;
    logic [ReadLatency-1:0] tagV_q, tagL_q;
    logic [DataBits-1:0] fifoData_q [FifoDepth];
    logic                fifoLast_q [FifoDepth];

    logic                issue, issueLast, push, pop, hasCredit;
    logic [AddrBits-1:0] issueAddr;
    logic [CntBits:0]    used;

    assign push    = tagV_q[ReadLatency-1];
    assign valid_o = (count_q != '0);
    assign pop     = valid_o & ready_i;
    assign data_o  = valid_o ? fifoData_q[rdPtr_q] : '0;
    assign last_o  = valid_o & fifoLast_q[rdPtr_q];
    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;
    assign mem_rd_en_o = rdEn_q;
    assign mem_addr_o  = rdAddr_q;

    // Reads in flight plus buffered beats must leave room for every outstanding return.
    assign used      = {1'b0, inFlight_q} + {1'b0, count_q} - {{CntBits{1'b0}}, pop};
    assign hasCredit = (used < (CntBits+1)'(FifoDepth));

    always_comb begin
        state_d   = state_q;
        curAddr_d = curAddr_q;
        endAddr_d = endAddr_q;
        issue     = 1'b0;
        issueAddr = curAddr_q;
        issueLast = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    issue     = 1'b1;
                    issueAddr = start_addr_i;
                    issueLast = (end_addr_i <= start_addr_i);
                    endAddr_d = end_addr_i;
                    curAddr_d = start_addr_i + AddrBits'(1);
                    state_d   = issueLast ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (hasCredit) begin
                    issue     = 1'b1;
                    issueLast = (curAddr_q == endAddr_q);
                    curAddr_d = curAddr_q + AddrBits'(1);
                    if (issueLast) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && last_o) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            curAddr_q  <= '0;
            endAddr_q  <= '0;
            done_q     <= 1'b0;
            rdEn_q     <= 1'b0;
            rdAddr_q   <= '0;
            rdLast_q   <= 1'b0;
            inFlight_q <= '0;
        end else begin
            state_q    <= state_d;
            curAddr_q  <= curAddr_d;
            endAddr_q  <= endAddr_d;
            done_q     <= done_d;
            rdEn_q     <= issue;
            if (issue) begin
                rdAddr_q <= issueAddr;
                rdLast_q <= issueLast;
            end
            inFlight_q <= inFlight_q + CntBits'(issue) - CntBits'(push);
        end
    end

    // Tags ride alongside the memory pipeline; clearing them on reset drops stale returns.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tagV_q <= '0;
            tagL_q <= '0;
        end else begin
            for (int i = ReadLatency - 1; i > 0; i--) begin
                tagV_q[i] <= tagV_q[i-1];
                tagL_q[i] <= tagL_q[i-1];
            end
            tagV_q[0] <= rdEn_q;
            tagL_q[0] <= rdLast_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push)
                wrPtr_q <= (wrPtr_q == PtrBits'(FifoDepth - 1)) ? '0 : wrPtr_q + PtrBits'(1);
            if (pop)
                rdPtr_q <= (rdPtr_q == PtrBits'(FifoDepth - 1)) ? '0 : rdPtr_q + PtrBits'(1);
            count_q <= count_q + CntBits'(push) - CntBits'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifoData_q[wrPtr_q] <= mem_data_i;
            fifoLast_q[wrPtr_q] <= tagL_q[ReadLatency-1];
        end
    end

    fifoNoOverflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !pop && count_q == CntBits'(FifoDepth)));

`ifdef MEM_READ_STREAMER_STALL_CNT_EN
    logic [15:0] stallCnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            stallCnt_q <= '0;
        else if (state_q == IDLE && start_i)
            stallCnt_q <= '0;
        else if (valid_o && !ready_i && stallCnt_q != 16'hFFFF)
            stallCnt_q <= stallCnt_q + 16'd1;
    end

    assign stall_cnt_o = stallCnt_q;
`else
    // No stall counter in this build.
`endif

endmodule

// File: tb/tb_mem_read_streamer.sv
`timescale 1ns/1ps
// Bench for mem_read_streamer: two instances (ReadLatency 1/FifoDepth 4 and ReadLatency 3/FifoDepth 5)
// share stimulus and are each checked every cycle against a transfer-level model.
module tb_mem_read_streamer;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] startAddr, endAddr;
    logic          ready;

    logic [1:0]    busyV, doneV, rdEnV, validV, lastV;
    logic [AW-1:0] addrV [2];
    logic [DW-1:0] dataV [2];
`ifdef MEM_READ_STREAMER_STALL_CNT_EN
    logic [15:0]   stallV [2];
`endif

    always #5 clk = ~clk;

    function automatic logic [7:0] memVal(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic int rlOf(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int depthOf(input int g);
        return (g == 0) ? 4 : 5;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int RL    = (g == 0) ? 1 : 3;
        localparam int Depth = (g == 0) ? 4 : 5;
        logic [DW-1:0] pipe [RL];
        logic          busy, done, rdEn, valid, last;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;

        mem_read_streamer #(.AddrBits(AW), .DataBits(DW), .ReadLatency(RL), .FifoDepth(Depth)) dut (
            .clk_i(clk), .rst_i(rst), .start_i(start),
            .start_addr_i(startAddr), .end_addr_i(endAddr),
            .busy_o(busy), .done_o(done),
            .mem_rd_en_o(rdEn), .mem_addr_o(addr), .mem_data_i(pipe[RL-1]),
            .data_o(data), .valid_o(valid), .ready_i(ready), .last_o(last)
`ifdef MEM_READ_STREAMER_STALL_CNT_EN
            , .stall_cnt_o(stallV[g])
`endif
        );

        // Synchronous-read RAM with RL register stages; junk data when not strobed.
        always @(posedge clk) begin
            for (int i = RL - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= rdEn ? memVal(addr) : 8'hEE;
        end

        assign busyV[g]  = busy;
        assign doneV[g]  = done;
        assign rdEnV[g]  = rdEn;
        assign validV[g] = valid;
        assign lastV[g]  = last;
        assign addrV[g]  = addr;
        assign dataV[g]  = data;
    end

    // Transfer-level model state, one slot per instance.
    bit   mBusy [2], mDone [2], firstSeen [2];
    bit   prevValid [2], prevLast [2], prevReady [2];
    int   prevData [2];
    int   sinceAccept [2], outstanding [2], strobeCount [2], doneDelay [2], accepts [2], mStall [2];
    int   expAddr [2][300];
    int   eaHead [2], eaTail [2];
    int   expData [2][300];
    bit   expLast [2][300];
    int   ebHead [2], ebTail [2];
    int   recData [2][16];
    bit   recLast [2][16];
    int   recCnt [2];
    int   refData [8];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input int g, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s (dut %0d): got 'h%0h, expected 'h%0h", name, g, act, exp);
    endtask

    task automatic failNow(input string name, input int g, input int act);
        total++;
        $display("[TB] FAIL %s (dut %0d): got 'h%0h, expected nothing", name, g, act);
    endtask

    task automatic zeroChecks(input int g);
        check("rst_busy", g, busyV[g], 0);
        check("rst_done", g, doneV[g], 0);
        check("rst_rd_en", g, rdEnV[g], 0);
        check("rst_addr", g, addrV[g], 0);
        check("rst_valid", g, validV[g], 0);
        check("rst_data", g, dataV[g], 0);
        check("rst_last", g, lastV[g], 0);
    endtask

    task automatic clearModel(input int g);
        mBusy[g] = 0; mDone[g] = 0; firstSeen[g] = 0;
        prevValid[g] = 0; prevLast[g] = 0; prevReady[g] = 0; prevData[g] = 0;
        eaHead[g] = 0; eaTail[g] = 0; ebHead[g] = 0; ebTail[g] = 0;
        outstanding[g] = 0; mStall[g] = 0;
    endtask

    task automatic loadTransfer(input int g);
        int sa, ea;
        sa = int'(startAddr);
        ea = int'(endAddr);
        eaHead[g] = 0; eaTail[g] = 0; ebHead[g] = 0; ebTail[g] = 0;
        if (ea < sa) ea = sa;
        for (int a = sa; a <= ea; a++) begin
            expAddr[g][eaTail[g]] = a;
            eaTail[g]++;
            expData[g][ebTail[g]] = int'(memVal(AW'(a)));
            expLast[g][ebTail[g]] = (a == ea);
            ebTail[g]++;
        end
    endtask

    // Per-cycle comparison of one instance against the model, then model advance.
    task automatic checkOutput(input int g);
        bit accept, endXfer;
        if (rst) begin
            zeroChecks(g);
            clearModel(g);
            return;
        end
        endXfer = 0;
        sinceAccept[g]++;
        check("busy", g, busyV[g], mBusy[g]);
        check("done", g, doneV[g], mDone[g]);
        if (mDone[g]) doneDelay[g] = sinceAccept[g];
        if (rdEnV[g]) begin
            strobeCount[g]++;
            outstanding[g]++;
            if (eaHead[g] < eaTail[g]) begin
                check("rd_addr", g, addrV[g], expAddr[g][eaHead[g]]);
                eaHead[g]++;
            end else failNow("extra_strobe", g, addrV[g]);
            check("credit", g, outstanding[g] <= depthOf(g), 1);
        end
        if (prevValid[g] && !prevReady[g]) begin
            check("valid_hold", g, validV[g], 1);
            check("data_hold", g, dataV[g], prevData[g]);
            check("last_hold", g, lastV[g], prevLast[g]);
        end
        if (!mBusy[g]) check("idle_valid", g, validV[g], 0);
        else if (!firstSeen[g]) begin
            check("first_valid", g, validV[g], sinceAccept[g] >= rlOf(g) + 2);
            if (validV[g]) firstSeen[g] = 1;
        end
`ifdef MEM_READ_STREAMER_STALL_CNT_EN
        check("stall_cnt", g, stallV[g], mStall[g]);
        if (validV[g] && !ready && mStall[g] != 65535) mStall[g]++;
`endif
        if (validV[g] && ready) begin
            outstanding[g]--;
            if (ebHead[g] < ebTail[g]) begin
                check("beat_data", g, dataV[g], expData[g][ebHead[g]]);
                check("beat_last", g, lastV[g], expLast[g][ebHead[g]]);
                if (recCnt[g] < 16) begin
                    recData[g][recCnt[g]] = dataV[g];
                    recLast[g][recCnt[g]] = lastV[g];
                    recCnt[g]++;
                end
                endXfer = expLast[g][ebHead[g]];
                ebHead[g]++;
            end else failNow("extra_beat", g, dataV[g]);
        end
        accept = !mBusy[g] && start;
        mDone[g] = endXfer;
        if (endXfer) mBusy[g] = 0;
        if (accept) begin
            loadTransfer(g);
            mBusy[g] = 1; firstSeen[g] = 0; sinceAccept[g] = 0;
            strobeCount[g] = 0; outstanding[g] = 0; recCnt[g] = 0; mStall[g] = 0;
            accepts[g]++;
        end
        prevValid[g] = validV[g];
        prevData[g]  = dataV[g];
        prevLast[g]  = lastV[g];
        prevReady[g] = ready;
    endtask

    task automatic tick();
        @(negedge clk);
        checkOutput(0);
        checkOutput(1);
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic s, input logic [AW-1:0] sa, input logic [AW-1:0] ea, input logic r);
        start     = s;
        startAddr = sa;
        endAddr   = ea;
        ready     = r;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while ((mBusy[0] || mBusy[1] || mDone[0] || mDone[1]) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) failNow({tag, "_timeout"}, 0, n);
        tick();
    endtask

    task automatic checkBeats(input string name, input int n);
        for (int g = 0; g < 2; g++) begin
            check({name, "_count"}, g, recCnt[g], n);
            for (int i = 0; i < n && i < recCnt[g]; i++) begin
                check({name, "_data"}, g, recData[g][i], refData[i]);
                check({name, "_last"}, g, recLast[g][i], i == n - 1);
            end
        end
    endtask

    initial begin
        int n;
        for (int g = 0; g < 2; g++) begin
            clearModel(g);
            recCnt[g] = 0; accepts[g] = 0; sinceAccept[g] = 0; strobeCount[g] = 0; doneDelay[g] = 0;
        end
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0);
        #1;
        zeroChecks(0);
        zeroChecks(1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: 0x010..0x017 with ready held high.
        applyStimulus(1'b1, 10'h010, 10'h017, 1'b1);
        tick();
        applyStimulus(1'b0, 10'h010, 10'h017, 1'b1);
        waitIdle("t1");
        refData = '{'h4A, 'h4B, 'h48, 'h49, 'h4E, 'h4F, 'h4C, 'h4D};
        checkBeats("t1", 8);
        check("t1_done_delay", 0, doneDelay[0], 11);
        check("t1_done_delay", 1, doneDelay[1], 13);

        // 2: same range, ready toggling every cycle.
        applyStimulus(1'b1, 10'h010, 10'h017, 1'b1);
        tick();
        applyStimulus(1'b0, 10'h010, 10'h017, 1'b0);
        n = 0;
        while ((mBusy[0] || mBusy[1]) && n < 400) begin
            ready = ~ready;
            tick();
            n++;
        end
        ready = 1'b1;
        waitIdle("t2");
        checkBeats("t2", 8);

        // 3: top of address space, output blocked for 10 cycles.
        applyStimulus(1'b1, 10'h3FC, 10'h3FF, 1'b0);
        tick();
        applyStimulus(1'b0, 10'h3FC, 10'h3FF, 1'b0);
        repeat (9) tick();
        check("t3_reads_before_release", 0, strobeCount[0], 4);
        check("t3_reads_before_release", 1, strobeCount[1], 4);
        ready = 1'b1;
        waitIdle("t3");
        refData = '{'hA6, 'hA7, 'hA4, 'hA5, 0, 0, 0, 0};
        checkBeats("t3", 4);

        // 4: reversed range gives a single beat.
        applyStimulus(1'b1, 10'h020, 10'h01F, 1'b1);
        tick();
        applyStimulus(1'b0, 10'h020, 10'h01F, 1'b1);
        waitIdle("t4");
        refData = '{'h7A, 0, 0, 0, 0, 0, 0, 0};
        checkBeats("t4", 1);

        // 5: asynchronous reset after the third beat, then a short transfer.
        applyStimulus(1'b1, 10'h000, 10'h0FF, 1'b1);
        tick();
        applyStimulus(1'b0, 10'h000, 10'h0FF, 1'b1);
        n = 0;
        while (recCnt[0] < 3 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) failNow("t5_beat_timeout", 0, recCnt[0]);
        rst = 1'b1;
        #1;
        zeroChecks(0);
        zeroChecks(1);
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        applyStimulus(1'b1, 10'h005, 10'h006, 1'b1);
        tick();
        applyStimulus(1'b0, 10'h005, 10'h006, 1'b1);
        waitIdle("t5");
        refData = '{'h5F, 'h5C, 0, 0, 0, 0, 0, 0};
        checkBeats("t5", 2);

        // 6: start held high; only idle/done-cycle samples start a transfer.
        accepts[0] = 0;
        accepts[1] = 0;
        applyStimulus(1'b1, 10'h030, 10'h032, 1'b1);
        repeat (20) tick();
        applyStimulus(1'b0, 10'h030, 10'h032, 1'b1);
        waitIdle("t6");
        check("t6_accepts", 0, accepts[0], 4);
        check("t6_accepts", 1, accepts[1], 3);
        refData = '{'h6A, 'h6B, 'h68, 0, 0, 0, 0, 0};
        checkBeats("t6", 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
